// File: rtl/router_pkg.sv
// Shared types and helpers for the parametrised 1xN packet router.
package router_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_EMPTY,
      ST_LFD,
      ST_LOAD,
      ST_DROP
   } state_e;

   // A header always carries at least one address bit, even when NUM_CH == 2.
   function automatic int addr_w(input int num_ch);
      return (num_ch > 2) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-channel fall-through FIFO with a synchronous flush used by the channel timeout.
module router_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic             do_wr, do_rd;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign do_wr   = wr_en && !full && !flush;
   assign do_rd   = rd_en && !empty && !flush;
   // Head word is forced to zero when empty so stale memory never reaches the port.
   assign rd_data = empty ? '0 : mem[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
         if (do_rd) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_q[PTR_W-1:0]] <= wr_data;
   end

endmodule

// File: rtl/router_1xn.sv
// 1-to-N packet router: header decode, per-channel buffering with sop tag,
// parity check, illegal-address drop and per-channel unread-data timeout.
module router_1xn
   import router_pkg::*;
#(
   parameter int NUM_CH     = 3,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT    = 30
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     pkt_valid,
   input  logic [DATA_W-1:0]        data_in,
   input  logic [NUM_CH-1:0]        read_en,
   output logic [NUM_CH*DATA_W-1:0] data_out,
   output logic [NUM_CH-1:0]        valid_out,
   output logic [NUM_CH-1:0]        sop_out,
   output logic                     busy,
   output logic                     err,
   output logic                     drop
);

   localparam int ADDR_W = addr_w(NUM_CH);
   localparam int CNT_W  = $clog2(TIMEOUT + 1);
   localparam int FW     = DATA_W + 1;

   state_e                        state_q, state_d;
   logic [DATA_W-1:0]             hdr_q, hdr_d;
   logic [DATA_W-1:0]             parity_q, parity_d;
   logic                          err_q, err_d;
   logic                          drop_q, drop_d;
   logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;

   logic [NUM_CH-1:0]             fifo_empty, fifo_full, fifo_wr, flush;
   logic [NUM_CH-1:0][FW-1:0]     fifo_rd_data;
   logic                          wr_req;
   logic [FW-1:0]                 wr_word;
   logic [ADDR_W-1:0]             in_addr, dest;
   logic                          in_illegal;

   assign in_addr    = data_in[ADDR_W-1:0];
   assign in_illegal = ({1'b0, in_addr} >= (ADDR_W+1)'(NUM_CH));
   assign dest       = hdr_q[ADDR_W-1:0];

   always_comb begin
      state_d  = state_q;
      hdr_d    = hdr_q;
      parity_d = parity_q;
      err_d    = err_q;
      drop_d   = 1'b0;
      wr_req   = 1'b0;
      wr_word  = '0;
      busy     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pkt_valid) begin
               hdr_d = data_in;
               err_d = 1'b0;
               if (in_illegal) begin
                  state_d = ST_DROP;
                  drop_d  = 1'b1;
               end else if (fifo_empty[in_addr]) begin
                  state_d = ST_LFD;
               end else begin
                  state_d = ST_WAIT_EMPTY;
               end
            end
         end
         ST_WAIT_EMPTY: begin
            busy = 1'b1;
            if (fifo_empty[dest]) state_d = ST_LFD;
         end
         ST_LFD: begin
            busy     = 1'b1;
            wr_req   = 1'b1;
            wr_word  = {1'b1, hdr_q};
            parity_d = hdr_q;
            state_d  = ST_LOAD;
         end
         ST_LOAD: begin
            busy = fifo_full[dest];
            if (flush[dest]) begin
               // Packet is lost; a parity byte taken this cycle already ends it.
               state_d = (!busy && !pkt_valid) ? ST_IDLE : ST_DROP;
            end else if (!busy) begin
               wr_req  = 1'b1;
               wr_word = {1'b0, data_in};
               if (pkt_valid) begin
                  parity_d = parity_q ^ data_in;
               end else begin
                  err_d   = (data_in != parity_q);
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DROP: begin
            if (!pkt_valid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Timeout counts consecutive cycles a channel holds data nobody reads.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         cnt_d[c] = '0;
         if (!flush[c] && valid_out[c] && !read_en[c]) cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         hdr_q    <= '0;
         parity_q <= '0;
         err_q    <= 1'b0;
         drop_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         hdr_q    <= hdr_d;
         parity_q <= parity_d;
         err_q    <= err_d;
         drop_q   <= drop_d;
         cnt_q    <= cnt_d;
      end
   end

   assign err  = err_q;
   assign drop = drop_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign flush[c]   = (cnt_q[c] == CNT_W'(TIMEOUT - 1));
      assign fifo_wr[c] = wr_req && (dest == ADDR_W'(c));

      router_fifo #(
         .WIDTH (FW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .resetn  (resetn),
         .flush   (flush[c]),
         .wr_en   (fifo_wr[c]),
         .wr_data (wr_word),
         .rd_en   (read_en[c]),
         .rd_data (fifo_rd_data[c]),
         .empty   (fifo_empty[c]),
         .full    (fifo_full[c])
      );

      assign data_out[c*DATA_W +: DATA_W] = fifo_rd_data[c][DATA_W-1:0];
      assign valid_out[c]                 = !fifo_empty[c];
      assign sop_out[c]                   = fifo_rd_data[c][DATA_W];
   end

endmodule

// File: tb/tb_router_1xn.sv
// Directed bench for router_1xn with NUM_CH=3, DATA_W=8, FIFO_DEPTH=16, TIMEOUT=30.
module tb_router_1xn;

   logic        clk = 1'b0;
   logic        resetn;
   logic        pkt_valid;
   logic [7:0]  data_in;
   logic [2:0]  read_en;
   logic [23:0] data_out;
   logic [2:0]  valid_out;
   logic [2:0]  sop_out;
   logic        busy;
   logic        err;
   logic        drop;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rise_cyc = 0;
   int last_len = -1;
   logic prev_v2 = 1'b0;

   router_1xn #(.NUM_CH(3), .DATA_W(8), .FIFO_DEPTH(16), .TIMEOUT(30)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .pkt_valid (pkt_valid),
      .data_in   (data_in),
      .read_en   (read_en),
      .data_out  (data_out),
      .valid_out (valid_out),
      .sop_out   (sop_out),
      .busy      (busy),
      .err       (err),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Length of the most recent valid_out[2] high period, in clock edges.
   always @(negedge clk) begin
      if (valid_out[2] && !prev_v2) rise_cyc = cyc;
      if (!valid_out[2] && prev_v2) last_len = cyc - rise_cyc;
      prev_v2 = valid_out[2];
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send(input logic [7:0] b, input logic pv);
      int n = 0;
      data_in   = b;
      pkt_valid = pv;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         errors++;
         $display("FAIL send_timeout byte %h busy stuck got %b exp 0", b, busy);
      end
      @(negedge clk);
      pkt_valid = 1'b0;
   endtask

   // Called at a negedge; samples the channel head then pops it for one cycle.
   task automatic pop(input int c, output logic v, output logic s, output logic [7:0] d);
      v = valid_out[c];
      s = sop_out[c];
      d = data_out[c*8 +: 8];
      read_en    = 3'b000;
      read_en[c] = 1'b1;
      @(negedge clk);
      read_en = 3'b000;
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      pkt_valid = 1'b0;
      data_in   = 8'h00;
      read_en   = 3'b000;
      repeat (2) @(negedge clk);
      checks++; if (valid_out !== 3'b000) begin errors++; $display("FAIL reset_valid got %b exp 000", valid_out); end
      checks++; if (sop_out !== 3'b000) begin errors++; $display("FAIL reset_sop got %b exp 000", sop_out); end
      checks++; if (data_out !== 24'h0) begin errors++; $display("FAIL reset_data got %h exp 000000", data_out); end
      checks++; if ({busy, err, drop} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, err, drop}); end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_good_packet();
      logic v, s;
      logic [7:0] d;
      send(8'h05, 1'b1);
      checks++; if (valid_out !== 3'b000) begin errors++; $display("FAIL hdr_latency got %b exp 000", valid_out); end
      send(8'hA5, 1'b1);
      send(8'hA0, 1'b0);
      checks++; if (valid_out !== 3'b010) begin errors++; $display("FAIL good_valid got %b exp 010", valid_out); end
      checks++; if ({err, drop} !== 2'b00) begin errors++; $display("FAIL good_err_drop got %b exp 00", {err, drop}); end
      pop(1, v, s, d);
      checks++; if ({v, s, d} !== {2'b11, 8'h05}) begin errors++; $display("FAIL good_w0 got %b%b %h exp 11 05", v, s, d); end
      pop(1, v, s, d);
      checks++; if ({v, s, d} !== {2'b10, 8'hA5}) begin errors++; $display("FAIL good_w1 got %b%b %h exp 10 a5", v, s, d); end
      pop(1, v, s, d);
      checks++; if ({v, s, d} !== {2'b10, 8'hA0}) begin errors++; $display("FAIL good_w2 got %b%b %h exp 10 a0", v, s, d); end
      checks++; if (valid_out !== 3'b000) begin errors++; $display("FAIL good_drained got %b exp 000", valid_out); end
   endtask

   task automatic test_bad_parity();
      logic v, s;
      logic [7:0] d;
      send(8'h05, 1'b1);
      send(8'hA5, 1'b1);
      send(8'h00, 1'b0);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err got %b exp 1", err); end
      pop(1, v, s, d);
      checks++; if ({v, s, d} !== {2'b11, 8'h05}) begin errors++; $display("FAIL bad_w0 got %b%b %h exp 11 05", v, s, d); end
      pop(1, v, s, d);
      checks++; if ({v, s, d} !== {2'b10, 8'hA5}) begin errors++; $display("FAIL bad_w1 got %b%b %h exp 10 a5", v, s, d); end
      pop(1, v, s, d);
      checks++; if ({v, s, d} !== {2'b10, 8'h00}) begin errors++; $display("FAIL bad_w2 got %b%b %h exp 10 00", v, s, d); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err_held got %b exp 1", err); end
      send(8'h05, 1'b1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_clear got %b exp 0", err); end
      send(8'h11, 1'b1);
      send(8'h14, 1'b0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL next_err got %b exp 0", err); end
      repeat (3) pop(1, v, s, d);
      checks++; if (valid_out !== 3'b000) begin errors++; $display("FAIL next_drained got %b exp 000", valid_out); end
   endtask

   task automatic test_drop();
      logic [7:0] pay [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      send(8'h03, 1'b1);
      checks++; if (drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", drop); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy%0d got %b exp 0", i, busy); end
         send(pay[i], 1'b1);
      end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_one_cycle got %b exp 0", drop); end
      send(8'h00, 1'b0);
      checks++; if ({valid_out, busy} !== 4'b0000) begin errors++; $display("FAIL drop_nowrite got %b exp 0000", {valid_out, busy}); end
   endtask

   task automatic test_full();
      logic [8:0] exp [22];
      logic v, s;
      logic [7:0] d;
      int k = 0;
      exp[0] = {1'b1, 8'h04};
      for (int i = 1; i <= 20; i++) exp[i] = {1'b0, 8'(i)};
      exp[21] = {1'b0, 8'h10};
      send(8'h04, 1'b1);
      for (int i = 1; i <= 15; i++) send(8'(i), 1'b1);
      for (int i = 16; i <= 21; i++) begin
         data_in   = exp[i][7:0];
         pkt_valid = (i != 21);
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy%0d got %b exp 1", i, busy); end
         pop(0, v, s, d);
         checks++; if ({v, s, d} !== {1'b1, exp[k]}) begin errors++; $display("FAIL full_pop%0d got %b%b %h exp 1 %h", k, v, s, d, exp[k]); end
         k++;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_release%0d got %b exp 0", i, busy); end
         @(negedge clk);
         pkt_valid = 1'b0;
      end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err got %b exp 0", err); end
      while (k < 22) begin
         pop(0, v, s, d);
         checks++; if ({v, s, d} !== {1'b1, exp[k]}) begin errors++; $display("FAIL full_pop%0d got %b%b %h exp 1 %h", k, v, s, d, exp[k]); end
         k++;
      end
      checks++; if (valid_out !== 3'b000) begin errors++; $display("FAIL full_drained got %b exp 000", valid_out); end
   endtask

   task automatic test_timeout();
      logic v, s;
      logic [7:0] d;
      send(8'h06, 1'b1);
      send(8'h3C, 1'b1);
      send(8'h3A, 1'b0);
      send(8'h06, 1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_wait_busy got %b exp 1", busy); end
      send(8'h55, 1'b1);
      send(8'h53, 1'b0);
      checks++; if (last_len !== 30) begin errors++; $display("FAIL tmo_len got %0d exp 30", last_len); end
      checks++; if (valid_out !== 3'b100) begin errors++; $display("FAIL tmo_valid got %b exp 100", valid_out); end
      pop(2, v, s, d);
      checks++; if ({v, s, d} !== {2'b11, 8'h06}) begin errors++; $display("FAIL tmo_w0 got %b%b %h exp 11 06", v, s, d); end
      pop(2, v, s, d);
      checks++; if ({v, s, d} !== {2'b10, 8'h55}) begin errors++; $display("FAIL tmo_w1 got %b%b %h exp 10 55", v, s, d); end
      pop(2, v, s, d);
      checks++; if ({v, s, d} !== {2'b10, 8'h53}) begin errors++; $display("FAIL tmo_w2 got %b%b %h exp 10 53", v, s, d); end
      checks++; if ({valid_out, err} !== 4'b0000) begin errors++; $display("FAIL tmo_end got %b exp 0000", {valid_out, err}); end
   endtask

   task automatic test_reset_mid();
      logic v, s;
      logic [7:0] d;
      send(8'h05, 1'b1);
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      data_in   = 8'h33;
      pkt_valid = 1'b1;
      resetn    = 1'b0;
      #1;
      checks++; if ({valid_out, sop_out} !== 6'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 000000", {valid_out, sop_out}); end
      checks++; if ({data_out, busy, err, drop} !== 27'h0) begin errors++; $display("FAIL rst_mid_out got %h %b%b%b exp 0", data_out, busy, err, drop); end
      @(negedge clk);
      resetn    = 1'b1;
      pkt_valid = 1'b0;
      @(negedge clk);
      send(8'h05, 1'b1);
      send(8'h77, 1'b1);
      send(8'h72, 1'b0);
      checks++; if ({valid_out, err} !== 4'b0100) begin errors++; $display("FAIL rst_next_state got %b exp 0100", {valid_out, err}); end
      pop(1, v, s, d);
      checks++; if ({v, s, d} !== {2'b11, 8'h05}) begin errors++; $display("FAIL rst_next_w0 got %b%b %h exp 11 05", v, s, d); end
      pop(1, v, s, d);
      checks++; if ({v, s, d} !== {2'b10, 8'h77}) begin errors++; $display("FAIL rst_next_w1 got %b%b %h exp 10 77", v, s, d); end
      pop(1, v, s, d);
      checks++; if ({v, s, d} !== {2'b10, 8'h72}) begin errors++; $display("FAIL rst_next_w2 got %b%b %h exp 10 72", v, s, d); end
   endtask

   initial begin
      test_reset();
      test_good_packet();
      test_bad_parity();
      test_drop();
      test_full();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
